// File: rtl/credit_tracker_pkg.sv
// credit_tracker_pkg: shared credit-count type for rename/dispatch consumers
package credit_tracker_pkg;
  localparam int NUM_ENTRIES_DEF = 32;
  localparam int CW_DEF = $clog2(NUM_ENTRIES_DEF) + 1;
  typedef logic [CW_DEF-1:0] credit_t;
endpackage

// File: rtl/credit_tracker_popcnt.sv
// PopCnt: population count of a SIZE-bit vector (in -> cnt, cnt is $clog2(SIZE)+1 bits)
module PopCnt #(
  parameter int SIZE = 32,
  localparam int W = $clog2(SIZE) + 1
) (
  input  logic [SIZE-1:0] in,
  output logic [W-1:0]    cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < SIZE; i++) cnt = cnt + W'(in[i]);
  end
endmodule

// File: rtl/credit_tracker.sv
// credit_tracker: free-credit counter with pipelined releases, alloc handshake and sticky over-release error (clk, rst, IN_flush, IN_allocValid, OUT_allocReady, IN_freeMask, OUT_freeCnt, OUT_err)
module credit_tracker
  import credit_tracker_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int ALLOC_WIDTH = 4,
  localparam int CW = $clog2(NUM_ENTRIES) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IN_flush,
  input  logic [ALLOC_WIDTH-1:0] IN_allocValid,
  output logic                   OUT_allocReady,
  input  logic [NUM_ENTRIES-1:0] IN_freeMask,
  output logic [CW-1:0]          OUT_freeCnt,
  output logic                   OUT_err
);
  localparam int AW = $clog2(ALLOC_WIDTH) + 1;
  localparam int SW = CW + 1;
  logic [CW-1:0] free_cnt, free_pend, free_pop;
  logic [AW-1:0] alloc_pop;
  logic [SW-1:0] sum;
  logic over;
  PopCnt #(.SIZE(NUM_ENTRIES)) u_free_pop (.in(IN_freeMask), .cnt(free_pop));
  PopCnt #(.SIZE(ALLOC_WIDTH)) u_alloc_pop (.in(IN_allocValid), .cnt(alloc_pop));
  assign OUT_allocReady = (free_cnt >= CW'(ALLOC_WIDTH)) && !IN_flush;
  // one extra bit so an over-release is seen before it wraps
  assign sum = {1'b0, free_cnt} - (OUT_allocReady ? SW'(alloc_pop) : '0) + {1'b0, free_pend};
  assign over = sum > SW'(NUM_ENTRIES);
  assign OUT_freeCnt = free_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt  <= CW'(NUM_ENTRIES);
      free_pend <= '0;
      OUT_err   <= 1'b0;
    end else if (IN_flush) begin
      free_cnt  <= CW'(NUM_ENTRIES);
      free_pend <= '0;
    end else begin
      free_cnt  <= over ? CW'(NUM_ENTRIES) : sum[CW-1:0];
      free_pend <= free_pop;
      OUT_err   <= OUT_err | over;
    end
  end
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    OUT_allocReady |-> free_cnt >= CW'(alloc_pop));
endmodule
